mesi_isc_cpu_agent: RTL and testbench

MESI_ISC_CPU_AGENT -- requirements
Module: mesi_isc_cpu_agent

---
 rtl/mesi_isc_cpu_agent.sv | 178 +++++++++++++++++
 tb/tb_mesi_isc_cpu_agent.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mesi_isc_cpu_agent.sv
// CPU-side agent of a MESI intersection controller: broadcasts CPU requests on the
// main bus, waits for the matching enable, then performs the access; snoops are acked independently.
module mesi_isc_cpu_agent #(
  parameter int ADDR_WIDTH     = 32,
  parameter int MBUS_CMD_WIDTH = 3,
  parameter int CBUS_CMD_WIDTH = 3,
  parameter int SNOOP_LAT      = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      cpu_req_i,
  input  logic                      cpu_wr_i,
  input  logic [ADDR_WIDTH-1:0]     cpu_addr_i,
  output logic                      cpu_ready_o,
  output logic                      cpu_done_o,
  output logic [MBUS_CMD_WIDTH-1:0] mbus_cmd_o,
  output logic [ADDR_WIDTH-1:0]     mbus_addr_o,
  input  logic                      mbus_ack_i,
  input  logic [CBUS_CMD_WIDTH-1:0] cbus_cmd_i,
  input  logic [ADDR_WIDTH-1:0]     cbus_addr_i,
  output logic                      cbus_ack_o,
  output logic [7:0]                snoop_cnt_o,
  output logic [1:0]                req_state_o,
  output logic [1:0]                snoop_state_o
);

  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_NOP      = MBUS_CMD_WIDTH'(0);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR       = MBUS_CMD_WIDTH'(1);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD       = MBUS_CMD_WIDTH'(2);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_WR_BROAD = MBUS_CMD_WIDTH'(3);
  localparam logic [MBUS_CMD_WIDTH-1:0] MBUS_RD_BROAD = MBUS_CMD_WIDTH'(4);

  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_WR_SNOOP = CBUS_CMD_WIDTH'(1);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_RD_SNOOP = CBUS_CMD_WIDTH'(2);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_WR    = CBUS_CMD_WIDTH'(3);
  localparam logic [CBUS_CMD_WIDTH-1:0] CBUS_EN_RD    = CBUS_CMD_WIDTH'(4);

  localparam logic [3:0] SNOOP_LAT4 = 4'(SNOOP_LAT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BROAD   = 2'd1,
    WAIT_EN = 2'd2,
    ACCESS  = 2'd3
  } req_state_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } snoop_state_t;

  req_state_t                r_req_state;
  logic                      r_lat_wr;
  logic [ADDR_WIDTH-1:0]     r_lat_addr;
  logic [MBUS_CMD_WIDTH-1:0] r_mbus_cmd;
  logic [ADDR_WIDTH-1:0]     r_mbus_addr;
  logic                      r_cpu_ready;
  logic                      r_cpu_done;
  logic                      r_en_ack;

  snoop_state_t              r_snoop_state;
  logic [3:0]                r_snoop_dn;
  logic                      r_snoop_ack;
  logic [7:0]                r_snoop_total;
  logic                      r_snoop_armed;

  logic                      w_en_match;
  logic                      w_is_snoop;

  assign w_en_match = (cbus_cmd_i == (r_lat_wr ? CBUS_EN_WR : CBUS_EN_RD)) &&
                      (cbus_addr_i == r_lat_addr);
  assign w_is_snoop = (cbus_cmd_i == CBUS_WR_SNOOP) || (cbus_cmd_i == CBUS_RD_SNOOP);

  // Request FSM: every output is a register updated on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_state <= IDLE;
      r_lat_wr    <= 1'b0;
      r_lat_addr  <= '0;
      r_mbus_cmd  <= MBUS_NOP;
      r_mbus_addr <= '0;
      r_cpu_ready <= 1'b1;
      r_cpu_done  <= 1'b0;
      r_en_ack    <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_en_ack   <= 1'b0;
      case (r_req_state)
        IDLE: begin
          if (cpu_req_i) begin
            r_lat_wr    <= cpu_wr_i;
            r_lat_addr  <= cpu_addr_i;
            r_mbus_cmd  <= cpu_wr_i ? MBUS_WR_BROAD : MBUS_RD_BROAD;
            r_mbus_addr <= cpu_addr_i;
            r_cpu_ready <= 1'b0;
            r_req_state <= BROAD;
          end
        end
        BROAD: begin
          if (mbus_ack_i) begin
            r_mbus_cmd  <= MBUS_NOP;
            r_req_state <= WAIT_EN;
          end
        end
        WAIT_EN: begin
          if (w_en_match) begin
            r_en_ack    <= 1'b1;
            r_mbus_cmd  <= r_lat_wr ? MBUS_WR : MBUS_RD;
            r_mbus_addr <= r_lat_addr;
            r_req_state <= ACCESS;
          end
        end
        ACCESS: begin
          if (mbus_ack_i) begin
            r_mbus_cmd  <= MBUS_NOP;
            r_cpu_done  <= 1'b1;
            r_cpu_ready <= 1'b1;
            r_req_state <= IDLE;
          end
        end
        default: r_req_state <= IDLE;
      endcase
    end
  end

  // A snoop is only captured once the bus has shown a non-snoop cycle since the
  // previous capture, so a command held past its ack is never acknowledged twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_snoop_state <= S_IDLE;
      r_snoop_dn    <= 4'd0;
      r_snoop_ack   <= 1'b0;
      r_snoop_total <= 8'd0;
      r_snoop_armed <= 1'b1;
    end else begin
      r_snoop_ack <= 1'b0;
      if (!w_is_snoop) begin
        r_snoop_armed <= 1'b1;
      end
      case (r_snoop_state)
        S_IDLE: begin
          if (w_is_snoop && r_snoop_armed) begin
            r_snoop_armed <= 1'b0;
            r_snoop_dn    <= SNOOP_LAT4;
            if (SNOOP_LAT4 == 4'd0) begin
              r_snoop_ack   <= 1'b1;
              r_snoop_state <= S_HOLD;
              if (r_snoop_total != 8'hFF) r_snoop_total <= r_snoop_total + 8'd1;
            end else begin
              r_snoop_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          r_snoop_dn <= r_snoop_dn - 4'd1;
          if (r_snoop_dn == 4'd1) begin
            r_snoop_ack   <= 1'b1;
            r_snoop_state <= S_HOLD;
            if (r_snoop_total != 8'hFF) r_snoop_total <= r_snoop_total + 8'd1;
          end
        end
        S_HOLD:  r_snoop_state <= S_IDLE;
        default: r_snoop_state <= S_IDLE;
      endcase
    end
  end

  assign cpu_ready_o   = r_cpu_ready;
  assign cpu_done_o    = r_cpu_done;
  assign mbus_cmd_o    = r_mbus_cmd;
  assign mbus_addr_o   = r_mbus_addr;
  assign cbus_ack_o    = r_en_ack | r_snoop_ack;
  assign snoop_cnt_o   = r_snoop_total;
  assign req_state_o   = r_req_state;
  assign snoop_state_o = r_snoop_state;

endmodule

// File: tb/tb_mesi_isc_cpu_agent.sv
// Randomized bench for mesi_isc_cpu_agent: drivers push expected main-bus commands,
// ack cycles and done cycles into queues; a negedge monitor pops and compares them.
module tb_mesi_isc_cpu_agent;

  localparam int LAT = 2;

  logic        clk;
  logic        rst;
  logic        cpu_req_i;
  logic        cpu_wr_i;
  logic [31:0] cpu_addr_i;
  logic        cpu_ready_o;
  logic        cpu_done_o;
  logic [2:0]  mbus_cmd_o;
  logic [31:0] mbus_addr_o;
  logic        mbus_ack_i;
  logic [2:0]  cbus_cmd_i;
  logic [31:0] cbus_addr_i;
  logic        cbus_ack_o;
  logic [7:0]  snoop_cnt_o;
  logic [1:0]  req_state_o;
  logic [1:0]  snoop_state_o;

  mesi_isc_cpu_agent #(
    .ADDR_WIDTH(32), .MBUS_CMD_WIDTH(3), .CBUS_CMD_WIDTH(3), .SNOOP_LAT(LAT)
  ) dut (
    .clk(clk), .rst(rst),
    .cpu_req_i(cpu_req_i), .cpu_wr_i(cpu_wr_i), .cpu_addr_i(cpu_addr_i),
    .cpu_ready_o(cpu_ready_o), .cpu_done_o(cpu_done_o),
    .mbus_cmd_o(mbus_cmd_o), .mbus_addr_o(mbus_addr_o), .mbus_ack_i(mbus_ack_i),
    .cbus_cmd_i(cbus_cmd_i), .cbus_addr_i(cbus_addr_i), .cbus_ack_o(cbus_ack_o),
    .snoop_cnt_o(snoop_cnt_o), .req_state_o(req_state_o), .snoop_state_o(snoop_state_o)
  );

  // ---------------- clock / reset / cycle counter ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [34:0] exp_mbus_q[$];   // {cmd, addr (0 when cmd is NOP)}
  logic [31:0] exp_ack_q[$];    // cycle in which cbus_ack_o must be high
  logic [31:0] exp_done_q[$];   // cycle in which cpu_done_o must be high
  logic [2:0]  bad_cmd_q[$];
  logic [31:0] bad_addr_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int model_cnt = 0;            // acknowledged snoops, saturating at 255

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    n_checks++;
    $display("FAIL %s: got 0x%0h, expected nothing (cycle %0d)", name, act, cyc);
  endtask

  // ---------------- monitor ----------------
  logic [34:0] prev_obs = '0;
  always @(negedge clk) begin
    logic [34:0] obs;
    logic [34:0] e;
    logic [31:0] ec;
    obs = {mbus_cmd_o, (mbus_cmd_o != 3'd0) ? mbus_addr_o : 32'd0};
    if (obs !== prev_obs) begin
      if (exp_mbus_q.size() == 0) fail_now("mbus_unexpected", 64'(obs));
      else begin
        e = exp_mbus_q.pop_front();
        chk("mbus_cmd_addr", 64'(obs), 64'(e));
      end
      prev_obs = obs;
    end
    if (cbus_ack_o === 1'b1) begin
      if (exp_ack_q.size() == 0) fail_now("cbus_ack_unexpected", 64'(cyc));
      else begin
        ec = exp_ack_q.pop_front();
        chk("cbus_ack_cycle", 64'(cyc), 64'(ec));
      end
    end
    if (cpu_done_o === 1'b1) begin
      if (exp_done_q.size() == 0) fail_now("cpu_done_unexpected", 64'(cyc));
      else begin
        ec = exp_done_q.pop_front();
        chk("cpu_done_cycle", 64'(cyc), 64'(ec));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ready"}, 64'(cpu_ready_o), 64'd1);
    chk({tag, "_done"},  64'(cpu_done_o),  64'd0);
    chk({tag, "_cmd"},   64'(mbus_cmd_o),  64'd0);
    chk({tag, "_addr"},  64'(mbus_addr_o), 64'd0);
    chk({tag, "_ack"},   64'(cbus_ack_o),  64'd0);
    chk({tag, "_cnt"},   64'(snoop_cnt_o), 64'd0);
  endtask

  // Snoop presented for `hold` cycles; the ack is due LAT+1 cycles after capture.
  task automatic do_snoop(input logic [2:0] cmd, input int hold, input logic [31:0] a);
    int c0;
    cbus_cmd_i  = cmd;
    cbus_addr_i = a;
    c0 = cyc;
    exp_ack_q.push_back(32'(c0 + LAT + 1));
    model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
    repeat (hold) step();
    cbus_cmd_i = 3'd0;
    step();
    while (cyc < c0 + LAT + 2) step();
    chk("snoop_cnt", 64'(snoop_cnt_o), 64'(model_cnt));
  endtask

  // One CPU transaction; wrong enables queued in bad_cmd_q/bad_addr_q are shown in WAIT_EN.
  task automatic do_request(input logic wr, input logic [31:0] addr, input int broad_wait,
                            input int acc_wait, input bit snoop_in_broad, input bit abort);
    int t;
    int bw;
    t = 0;
    while (cpu_ready_o !== 1'b1 && t < 50) begin step(); t++; end
    chk("ready_before_req", 64'(cpu_ready_o), 64'd1);
    cpu_req_i  = 1'b1;
    cpu_wr_i   = wr;
    cpu_addr_i = addr;
    exp_mbus_q.push_back({wr ? 3'd3 : 3'd4, addr});
    step();
    cpu_req_i  = 1'b0;
    cpu_wr_i   = 1'($urandom);
    cpu_addr_i = $urandom;
    chk("ready_busy", 64'(cpu_ready_o), 64'd0);
    bw = broad_wait;
    if (snoop_in_broad) begin
      cbus_cmd_i  = 3'd1;
      cbus_addr_i = addr;
      exp_ack_q.push_back(32'(cyc + LAT + 1));
      model_cnt = (model_cnt >= 255) ? 255 : model_cnt + 1;
      step();
      cbus_cmd_i = 3'd0;
      bw = LAT + 3;
    end
    repeat (bw) step();
    mbus_ack_i = 1'b1;
    exp_mbus_q.push_back(35'd0);
    step();
    mbus_ack_i = 1'b0;
    while (bad_cmd_q.size() > 0) begin
      cbus_cmd_i  = bad_cmd_q.pop_front();
      cbus_addr_i = bad_addr_q.pop_front();
      mbus_ack_i  = 1'($urandom_range(0, 1));
      step();
    end
    mbus_ack_i  = 1'b0;
    cbus_cmd_i  = wr ? 3'd3 : 3'd4;
    cbus_addr_i = addr;
    exp_ack_q.push_back(32'(cyc + 1));
    exp_mbus_q.push_back({wr ? 3'd1 : 3'd2, addr});
    step();
    cbus_cmd_i = 3'd0;
    if (abort) begin
      step();
      #2;
      rst = 1'b1;
      exp_mbus_q.push_back(35'd0);
      model_cnt = 0;
      #1;
      check_reset_outputs("abort");
      step();
      step();
      rst = 1'b0;
      step();
      return;
    end
    repeat (acc_wait) step();
    mbus_ack_i = 1'b1;
    exp_mbus_q.push_back(35'd0);
    exp_done_q.push_back(32'(cyc + 1));
    step();
    mbus_ack_i = 1'b0;
    chk("ready_after_done", 64'(cpu_ready_o), 64'd1);
    chk("snoop_cnt_req", 64'(snoop_cnt_o), 64'(model_cnt));
  endtask

  task automatic gen_bad(input logic wr, input logic [31:0] addr, input int nb);
    int k;
    for (int b = 0; b < nb; b++) begin
      k = $urandom_range(0, 2);
      if (k == 0) begin
        bad_cmd_q.push_back(wr ? 3'd4 : 3'd3);
        bad_addr_q.push_back(addr);
      end else if (k == 1) begin
        bad_cmd_q.push_back(wr ? 3'd3 : 3'd4);
        bad_addr_q.push_back(addr ^ (32'd1 << $urandom_range(0, 31)));
      end else begin
        bad_cmd_q.push_back(3'd0);
        bad_addr_q.push_back(addr);
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        wr;
    logic [31:0] addr;
    rst = 1'b0; cpu_req_i = 1'b0; cpu_wr_i = 1'b0; cpu_addr_i = '0;
    mbus_ack_i = 1'b0; cbus_cmd_i = 3'd0; cbus_addr_i = '0;
    #1 rst = 1'b1;
    step();
    check_reset_outputs("reset");
    step();
    rst = 1'b0;
    step();

    // held snoop: one ack LAT+1 cycles after capture
    do_snoop(3'd2, 6, 32'h40);
    // write flow at 0x10
    do_request(1'b1, 32'h10, 1, 1, 1'b0, 1'b0);
    // read at 0x20 with wrong-address and wrong-type enables first
    bad_cmd_q.push_back(3'd4); bad_addr_q.push_back(32'h24);
    bad_cmd_q.push_back(3'd3); bad_addr_q.push_back(32'h20);
    do_request(1'b0, 32'h20, 0, 2, 1'b0, 1'b0);
    // snoop to the same address while broadcasting
    do_request(1'b1, 32'h80, 0, 0, 1'b1, 1'b0);

    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0, 1: begin
          wr   = 1'($urandom_range(0, 1));
          addr = $urandom;
          gen_bad(wr, addr, $urandom_range(0, 3));
          do_request(wr, addr, $urandom_range(0, 3), $urandom_range(0, 3),
                     ($urandom_range(0, 3) == 0), 1'b0);
        end
        2: do_snoop(3'($urandom_range(1, 2)), $urandom_range(1, LAT + 4), $urandom);
        default: begin
          // stray acks and enables while idle must be ignored
          mbus_ack_i  = 1'b1;
          cbus_cmd_i  = 3'($urandom_range(3, 4));
          cbus_addr_i = $urandom;
          step();
          mbus_ack_i = 1'b0;
          cbus_cmd_i = 3'd0;
          step();
        end
      endcase
    end

    // saturation
    for (int i = 0; i < 300; i++) do_snoop(3'($urandom_range(1, 2)), 1, $urandom);
    chk("snoop_cnt_saturated", 64'(snoop_cnt_o), 64'd255);

    // reset while in ACCESS
    do_request(1'b1, 32'hABCD_0000, 0, 0, 1'b0, 1'b1);
    do_request(1'b0, 32'h0000_1234, 1, 1, 1'b0, 1'b0);
    do_snoop(3'd1, 1, 32'h1234);

    repeat (5) step();
    chk("mbus_q_drained", 64'(exp_mbus_q.size()), 64'd0);
    chk("ack_q_drained",  64'(exp_ack_q.size()),  64'd0);
    chk("done_q_drained", 64'(exp_done_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
